// File: rtl/seq_comp_pkg.sv
// -----------------------------------------------------------------------------
// seq_comp_pkg
// Shared definitions for the sequential magnitude comparator:
//   DEFAULT_WIDTH : default operand width (even, >= 2)
//   state_t       : controller state encoding (IDLE / COMPARE / DONE)
// -----------------------------------------------------------------------------
package seq_comp_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mag_comp_if.sv
// -----------------------------------------------------------------------------
// seq_mag_comp_if
// Request/result bundle of seq_mag_comp.
//   start, a, b          : request (driven by master)
//   busy, done           : status (driven by slave)
//   agtb, altb, aeqb     : registered result flags
//   state                : controller state, for observation only
//
// Handshake: a request is accepted on the rising edge where start=1 and the
// controller is in IDLE (busy=0, done=0); start is ignored at any other time
// and nothing is queued. done is a single-cycle pulse; the result flags are
// valid from the done cycle until the next accepted request.
// -----------------------------------------------------------------------------
interface seq_mag_comp_if
    import seq_comp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             agtb;
    logic             altb;
    logic             aeqb;
    state_t           state;

    modport master (
        output start, a, b,
        input  busy, done, agtb, altb, aeqb, state
    );

    modport slave (
        input  start, a, b,
        output busy, done, agtb, altb, aeqb, state
    );
endinterface

// File: rtl/cmp2_slice.sv
// -----------------------------------------------------------------------------
// cmp2_slice
// Combinational 2-bit unsigned magnitude comparator.
//   x, y : 2-bit operands
//   gt   : x > y
//   lt   : x < y
//   eq   : x == y
// -----------------------------------------------------------------------------
module cmp2_slice (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic       gt,
    output logic       lt,
    output logic       eq
);
    always_comb begin
        gt = (x > y);
        lt = (x < y);
        eq = (x == y);
    end
endmodule

// File: rtl/seq_mag_comp.sv
// -----------------------------------------------------------------------------
// seq_mag_comp
// Sequential unsigned magnitude comparator. Operands are latched on an accepted
// start and compared two bits per cycle from the MSB pair downwards; the first
// unequal pair decides the result, otherwise the operands are equal.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (priority over start)
//   bus  : seq_mag_comp_if.slave (start, a, b in; busy, done, flags, state out)
// WIDTH must be even and at least 2.
// -----------------------------------------------------------------------------
module seq_mag_comp
    import seq_comp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    seq_mag_comp_if.slave   bus
);
    localparam int NP = WIDTH / 2;
    localparam int IW = (NP > 1) ? $clog2(NP) : 1;

    state_t           state, state_n;
    logic [IW-1:0]    idx, idx_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] b_q, b_n;
    logic             agtb_q, agtb_n;
    logic             altb_q, altb_n;
    logic             aeqb_q, aeqb_n;

    logic [1:0]       pa, pb;
    logic             s_gt, s_lt, s_eq;

    // Pair i occupies bits [2i+1:2i]; {idx,1'b0} is 2*i.
    always_comb begin
        pa = a_q[{idx, 1'b0} +: 2];
        pb = b_q[{idx, 1'b0} +: 2];
    end

    cmp2_slice u_slice (
        .x  (pa),
        .y  (pb),
        .gt (s_gt),
        .lt (s_lt),
        .eq (s_eq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            agtb_q <= 1'b0;
            altb_q <= 1'b0;
            aeqb_q <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            a_q    <= a_n;
            b_q    <= b_n;
            agtb_q <= agtb_n;
            altb_q <= altb_n;
            aeqb_q <= aeqb_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        a_n     = a_q;
        b_n     = b_q;
        agtb_n  = agtb_q;
        altb_n  = altb_q;
        aeqb_n  = aeqb_q;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    a_n     = bus.a;
                    b_n     = bus.b;
                    idx_n   = IW'(NP - 1);
                    // Flags read 0 for the whole comparison.
                    agtb_n  = 1'b0;
                    altb_n  = 1'b0;
                    aeqb_n  = 1'b0;
                    state_n = COMPARE;
                end
            end
            COMPARE: begin
                if (!s_eq) begin
                    // First differing pair from the top decides the order.
                    agtb_n  = s_gt;
                    altb_n  = s_lt;
                    aeqb_n  = 1'b0;
                    state_n = DONE;
                end else if (idx == '0) begin
                    agtb_n  = 1'b0;
                    altb_n  = 1'b0;
                    aeqb_n  = 1'b1;
                    state_n = DONE;
                end else begin
                    idx_n   = idx - IW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Status decoded from state only; no input reaches an output combinationally.
    assign bus.busy  = (state == COMPARE);
    assign bus.done  = (state == DONE);
    assign bus.agtb  = agtb_q;
    assign bus.altb  = altb_q;
    assign bus.aeqb  = aeqb_q;
    assign bus.state = state;

endmodule

// File: tb/tb_seq_mag_comp.sv
// -----------------------------------------------------------------------------
// tb_seq_mag_comp
// Self-checking bench for seq_mag_comp with WIDTH=8.
// -----------------------------------------------------------------------------
module tb_seq_mag_comp;
    import seq_comp_pkg::*;

    localparam int W  = 8;
    localparam int NP = W / 2;
    localparam int EW = 11;   // {pairs[7:0], gt, lt, eq}

    logic clk = 1'b0;
    logic rst;

    seq_mag_comp_if #(.WIDTH(W)) bus ();

    seq_mag_comp #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Reference: the ordering comes from plain unsigned comparison; the number
    // of pairs examined is how far down from the top the highest differing bit
    // sits (all pairs when the operands are equal).
    function automatic logic [EW-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W-1:0] d;
        int           k;
        d = av ^ bv;
        k = NP;
        for (int bit_i = 0; bit_i < W; bit_i++)
            if (d[bit_i]) k = NP - (bit_i / 2);
        return {8'(k), av > bv, av < bv, av == bv};
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge with the DUT in IDLE; returns at the negedge of the
    // IDLE cycle right after DONE, so consecutive calls run back-to-back.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input int ek, input logic egt, input logic elt,
                         input logic eeq, input string nm);
        int            cyc;
        logic [EW-1:0] e;
        exp_q.push_back({8'(ek), egt, elt, eeq});
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(negedge clk);
        // Latched copies must be the only thing compared.
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        check({nm, " busy_after_accept"}, 32'(bus.busy), 32'd1);
        check({nm, " flags_cleared"}, 32'({bus.agtb, bus.altb, bus.aeqb}), 32'd0);
        cyc = 1;
        while (!bus.done && cyc < 20) begin
            @(negedge clk);
            bus.a = W'($urandom);
            cyc++;
        end
        e = exp_q.pop_front();
        check({nm, " done_seen"}, 32'(bus.done), 32'd1);
        check({nm, " latency"}, 32'(cyc), 32'(e[10:3]) + 32'd1);
        check({nm, " flags"}, 32'({bus.agtb, bus.altb, bus.aeqb}), 32'(e[2:0]));
        @(negedge clk);
        check({nm, " done_one_cycle"}, 32'(bus.done), 32'd0);
        check({nm, " idle_after_done"}, 32'(bus.state), 32'(IDLE));
        check({nm, " flags_held"}, 32'({bus.agtb, bus.altb, bus.aeqb}), 32'(e[2:0]));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           k;
        logic         gt;
        logic         lt;
        logic         eq;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int            dn, dc;
        logic [2:0]    fl;
        logic [W-1:0]  av, bv;
        logic [EW-1:0] r;

        tbl[0] = '{8'hA5, 8'hA5, 4, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{8'h01, 8'h02, 4, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{8'hC0, 8'h40, 1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'h12, 8'h13, 4, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{8'h00, 8'h00, 4, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{8'hFF, 8'h00, 1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{8'h0C, 8'h08, 3, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{8'h00, 8'hFF, 1, 1'b0, 1'b1, 1'b0};

        // ---- reset ----
        rst       = 1'b1;
        bus.start = 1'b1;   // reset must win over start
        bus.a     = 8'h55;
        bus.b     = 8'hAA;
        repeat (3) @(negedge clk);
        check("reset state", 32'(bus.state), 32'(IDLE));
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset flags", 32'({bus.agtb, bus.altb, bus.aeqb}), 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);

        // ---- table vectors, issued back-to-back ----
        for (int i = 0; i < 8; i++)
            do_op(tbl[i].a, tbl[i].b, tbl[i].k, tbl[i].gt, tbl[i].lt, tbl[i].eq,
                  $sformatf("vec%0d", i));

        // ---- start pulsed while busy and in DONE, operand changed ----
        bus.start = 1'b1;
        bus.a     = 8'h30;
        bus.b     = 8'h20;
        @(negedge clk);
        dn = 0;
        dc = 0;
        fl = 3'b000;
        for (int c = 1; c <= 10; c++) begin
            if (bus.done) begin
                dn++;
                dc = c;
                fl = {bus.agtb, bus.altb, bus.aeqb};
            end
            bus.start = (c <= 3);
            if (c == 1) bus.a = 8'h00;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("ignore_start done_count", 32'(dn), 32'd1);
        check("ignore_start done_cycle", 32'(dc), 32'd3);
        check("ignore_start flags", 32'(fl), 32'b100);
        check("ignore_start flags_held", 32'({bus.agtb, bus.altb, bus.aeqb}), 32'b100);

        // ---- reset in the second COMPARE cycle ----
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("abort in_compare", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort state", 32'(bus.state), 32'(IDLE));
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort flags", 32'({bus.agtb, bus.altb, bus.aeqb}), 32'd0);
        dn = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.done) dn++;
            @(negedge clk);
        end
        check("abort no_done", 32'(dn), 32'd0);

        // ---- randomized against the reference model ----
        for (int n = 0; n < 200; n++) begin
            av = W'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0:       bv = av;
                1:       bv = av ^ (W'(1) << $urandom_range(0, W - 1));
                default: bv = W'($urandom_range(0, 255));
            endcase
            r = model(av, bv);
            do_op(av, bv, int'(r[10:3]), r[2], r[1], r[0], $sformatf("rnd%0d", n));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_mag_comp.md
SEQ_MAG_COMP -- requirements
Module: seq_mag_comp

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, the operand width in bits; it must be even and at least 2.
REQ-002 SHALL provide port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst, input, 1 bit, reset; reset is synchronous and active-high.
REQ-004 SHALL provide port start, input, 1 bit, request to begin a comparison; it is sampled only in IDLE.
REQ-005 SHALL provide port a, input, WIDTH bits, the first operand; it is latched on an accepted start.
REQ-006 SHALL provide port b, input, WIDTH bits, the second operand; it is latched on an accepted start.
REQ-007 SHALL provide port busy, output, 1 bit, high while in the COMPARE state.
REQ-008 SHALL provide port done, output, 1 bit, a one-cycle completion pulse.
REQ-009 SHALL provide ports agtb, altb and aeqb, outputs, 1 bit each, the registered result flags (a>b, a<b, a==b).

Function
REQ-010 SHALL implement a three-state FSM: IDLE, COMPARE, DONE.
REQ-011 SHALL, in IDLE with start=1, perform these actions in the same cycle:
- latch a and b;
- set the pair index to WIDTH/2-1 (the MSB pair);
- go to COMPARE.
REQ-012 SHALL, in each COMPARE cycle, evaluate exactly one 2-bit pair {a[2i+1:2i], b[2i+1:2i]} through the 2-bit comparator slice.
REQ-013 SHALL, when a pair is unequal, register agtb or altb from the slice, clear the other two flags, and go to DONE (early termination).
REQ-014 SHALL, when a pair is equal and i>0, decrement i and remain in COMPARE.
REQ-015 SHALL, when a pair is equal and i==0, register aeqb=1, agtb=0, altb=0, and go to DONE.
REQ-016 SHALL spend 1 to WIDTH/2 cycles in COMPARE, equal to the number of pairs examined.
REQ-017 SHALL assert done=1 for exactly the single DONE cycle, then return to IDLE unconditionally.
REQ-018 SHALL, counting from the start-accept edge, raise done in the cycle after the last COMPARE cycle. Latency is therefore k+1 cycles, where k is the number of pairs examined.
REQ-019 SHALL ignore start whenever the FSM is in COMPARE or DONE; there is no queueing.
REQ-020 SHALL not be affected by changes on a or b after acceptance; the latched copies alone are compared.
REQ-021 SHALL hold the result flags from DONE until the next accepted start.
REQ-022 SHALL clear all three result flags on the accept edge, so they read 0 while busy.
REQ-023 SHALL have exactly one result flag high after any completed comparison, and none high while busy or after reset.
REQ-024 SHALL use a pair index of width ceil(log2(WIDTH/2)), with a minimum of 1 bit; no wrap below 0 occurs, because i==0 always exits.
REQ-025 SHALL accept start in IDLE on the cycle immediately following DONE; back-to-back operations are allowed.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, force state IDLE, pair index 0, busy=0, done=0, agtb=0, altb=0, aeqb=0, and cleared operand registers.
REQ-027 SHALL, on rst during COMPARE or DONE, abort the operation with no done pulse and no result update.
REQ-028 SHALL give rst priority over start in the same cycle.

Structure
REQ-029 SHALL place the FSM state encoding typedef (IDLE/COMPARE/DONE) and the default WIDTH constant in a shared package, seq_comp_pkg.
REQ-030 SHALL instantiate one combinational sub-module, cmp2_slice, a 2-bit magnitude comparator with gt, lt and eq outputs, fed by muxed latched pairs.
REQ-031 SHALL contain no combinational path from any input to any output; all outputs are registered or decoded from state.

Verification (WIDTH=8)
REQ-032 SHALL cover: a=8'hA5, b=8'hA5, start -> 4 COMPARE cycles, done in cycle 5 after accept, aeqb=1, agtb=altb=0.
REQ-033 SHALL cover: a=8'hC0, b=8'h40 -> 1 COMPARE cycle, done in cycle 2, agtb=1.
REQ-034 SHALL cover: a=8'h12, b=8'h13 -> 4 COMPARE cycles, done in cycle 5, altb=1.
REQ-035 SHALL cover: start with a=8'h30, b=8'h20, then while busy pulse start and change to a=8'h00 -> one done only, with agtb=1 after 2 COMPARE cycles.
REQ-036 SHALL cover: rst=1 in the second COMPARE cycle of a=8'hFF, b=8'hFF -> next cycle IDLE, busy=0, all flags 0, no done pulse.
REQ-037 SHALL cover: start asserted in the cycle after DONE with a=8'h01, b=8'h02 -> accepted, altb=1 after 4 COMPARE cycles, with the prior result cleared on accept.
